// File: rtl/turbine_pulse_counter_array.sv
// Multi-channel turbine pulse counter: per-channel sync/filter/edge count, snapshot on start,
// serialised valid/ready readout. Optional glitch filter enabled by TURBINE_GLITCH_FILT_EN.
`timescale 1ns/1ps
module turbine_pulse_counter_array #(
  parameter int TURBINE_NUM = 10,
  parameter int CNT_WIDTH   = 16,
  parameter int FILT_LEN    = 4,
  localparam int CH_W       = (TURBINE_NUM > 1) ? $clog2(TURBINE_NUM) : 1
) (
  input  logic                   sys_clk_i,
  input  logic                   rst_i,
  input  logic                   turbine_acq_start_pluse_i,
  input  logic [TURBINE_NUM-1:0] turbine_pulse_i,
  input  logic                   wr_ready_i,
  output logic                   wr_en_o,
  output logic [CNT_WIDTH-1:0]   wr_din_o,
  output logic [CH_W-1:0]        wr_ch_o,
  output logic                   wr_ovf_o,
  output logic                   busy_o,
  output logic                   acq_miss_o
);

`ifdef TURBINE_GLITCH_FILT_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(TURBINE_NUM - 1);

  logic                 snap_take;
  logic [CNT_WIDTH-1:0] cnt0;
  logic                 ovf0;
  logic [CNT_WIDTH-1:0] snap_cnt [TURBINE_NUM];
  logic [TURBINE_NUM-1:0] snap_ovf;

  for (genvar i = 0; i < TURBINE_NUM; i++) begin : g_ch
    logic                 sync1_q, sync2_q, lvl, lvl_d_q, edge_det, ovf_q, snap_ovf_q;
    logic [CNT_WIDTH-1:0] cnt_q, snap_q;

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        lvl_d_q <= 1'b0;
      end else begin
        sync1_q <= turbine_pulse_i[i];
        sync2_q <= sync1_q;
        lvl_d_q <= lvl;
      end
    end

    if (FILT_EN && FILT_LEN > 0) begin : g_filt
      localparam logic [7:0] FILT_TC = 8'(FILT_LEN - 1);
      logic       lvl_q;
      logic [7:0] tmr_q;

      // Down-counter runs only while the synchronised input disagrees with the level.
      always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
          lvl_q <= 1'b0;
          tmr_q <= FILT_TC;
        end else if (sync2_q == lvl_q) begin
          tmr_q <= FILT_TC;
        end else if (tmr_q == 8'd0) begin
          lvl_q <= sync2_q;
          tmr_q <= FILT_TC;
        end else begin
          tmr_q <= tmr_q - 8'd1;
        end
      end
      assign lvl = lvl_q;
    end else begin : g_nofilt
      assign lvl = sync2_q;
    end

    assign edge_det = lvl & ~lvl_d_q;

    // An edge coinciding with the snapshot belongs to the new window.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (snap_take) begin
        cnt_q <= CNT_WIDTH'(edge_det);
        ovf_q <= 1'b0;
      end else if (edge_det) begin
        if (&cnt_q) ovf_q <= 1'b1;
        else        cnt_q <= cnt_q + 1'b1;
      end
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) begin
        snap_q     <= '0;
        snap_ovf_q <= 1'b0;
      end else if (snap_take) begin
        snap_q     <= cnt_q;
        snap_ovf_q <= ovf_q;
      end
    end

    assign snap_cnt[i] = snap_q;
    assign snap_ovf[i] = snap_ovf_q;

    if (i == 0) begin : g_ch0
      assign cnt0 = cnt_q;
      assign ovf0 = ovf_q;
    end
  end

  // state | meaning
  // IDLE  | counting, waiting for an acquisition start
  // SEND  | streaming snapshot words, wr_ch_o is the channel pointer
  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic                 en_d, ovf_d, busy_d, miss_d, xfer;
  logic [CNT_WIDTH-1:0] din_d;
  logic [CH_W-1:0]      ch_d, ch_inc;

  assign xfer   = wr_en_o & wr_ready_i;
  assign ch_inc = wr_ch_o + 1'b1;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_en_o    <= 1'b0;
      wr_din_o   <= '0;
      wr_ch_o    <= '0;
      wr_ovf_o   <= 1'b0;
      busy_o     <= 1'b0;
      acq_miss_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_en_o    <= en_d;
      wr_din_o   <= din_d;
      wr_ch_o    <= ch_d;
      wr_ovf_o   <= ovf_d;
      busy_o     <= busy_d;
      acq_miss_o <= miss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    en_d      = wr_en_o;
    din_d     = wr_din_o;
    ch_d      = wr_ch_o;
    ovf_d     = wr_ovf_o;
    miss_d    = 1'b0;
    snap_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (turbine_acq_start_pluse_i) begin
          // Snapshot lands on the same edge, so word 0 comes straight from the live counter.
          state_d   = SEND;
          snap_take = 1'b1;
          en_d      = 1'b1;
          din_d     = cnt0;
          ovf_d     = ovf0;
          ch_d      = '0;
        end
      end
      SEND: begin
        miss_d = turbine_acq_start_pluse_i;
        if (xfer) begin
          if (wr_ch_o == LAST_CH) begin
            state_d = IDLE;
            en_d    = 1'b0;
            din_d   = '0;
            ch_d    = '0;
            ovf_d   = 1'b0;
          end else begin
            ch_d  = ch_inc;
            din_d = snap_cnt[ch_inc];
            ovf_d = snap_ovf[ch_inc];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SEND);
  end

endmodule

// File: tb/tb_turbine_pulse_counter_array.sv
// Randomised bench for turbine_pulse_counter_array against a pulse-accounting reference model.
`timescale 1ns/1ps
module tb_turbine_pulse_counter_array;
  localparam int NCH     = 10;
  localparam int CW      = 4;
  localparam int FL      = 4;
  localparam int CHW     = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef TURBINE_GLITCH_FILT_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif
  localparam int LAT = FILT_ON ? 3 + FL : 3;

  logic           clk = 1'b0;
  logic           rst, start, rdy;
  logic [NCH-1:0] pins;
  logic           wr_en, wr_ovf, busy, miss;
  logic [CW-1:0]  din;
  logic [CHW-1:0] ch;

  int acc [NCH];
  int exp_cnt [NCH];
  bit exp_ovf [NCH];
  int n_checks = 0;
  int n_pass   = 0;

  turbine_pulse_counter_array #(.TURBINE_NUM(NCH), .CNT_WIDTH(CW), .FILT_LEN(FL)) dut (
    .sys_clk_i(clk), .rst_i(rst), .turbine_acq_start_pluse_i(start),
    .turbine_pulse_i(pins), .wr_ready_i(rdy), .wr_en_o(wr_en), .wr_din_o(din),
    .wr_ch_o(ch), .wr_ovf_o(wr_ovf), .busy_o(busy), .acq_miss_o(miss));

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0d required %0d", tag, got, expv);
  endtask

  // A pulse survives the front end if it is at least FILT_LEN cycles wide (filter) or any width.
  task automatic pulses(input int c, input int n, input int w, input int g);
    for (int k = 0; k < n; k++) begin
      pins[c] = 1'b1;
      repeat (w) @(negedge clk);
      pins[c] = 1'b0;
      repeat (g) @(negedge clk);
      if (!FILT_ON || w >= FL) acc[c]++;
    end
  endtask

  task automatic settle();
    repeat (LAT + 4) @(negedge clk);
  endtask

  task automatic do_start();
    for (int c = 0; c < NCH; c++) begin
      exp_cnt[c] = (acc[c] > CNT_MAX) ? CNT_MAX : acc[c];
      exp_ovf[c] = (acc[c] > CNT_MAX);
      acc[c]     = 0;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("miss_on_accept", 32'(miss), 0);
  endtask

  // mode: 0 ready always, 1 ready alternating 0/1, 2 ready random
  task automatic collect(input int mode, input bit start_on_last);
    int idx   = 0;
    int guard = 0;
    int cyc   = 0;
    while (idx < NCH && guard < 200) begin
      guard++;
      chk("busy", 32'(busy), 1);
      chk("wr_en", 32'(wr_en), 1);
      chk("wr_ch", 32'(ch), idx);
      chk("wr_din", 32'(din), exp_cnt[idx]);
      chk("wr_ovf", 32'(wr_ovf), 32'(exp_ovf[idx]));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      start = start_on_last && rdy && (idx == NCH - 1);
      if (rdy) idx++;
      cyc++;
      @(negedge clk);
      start = 1'b0;
    end
    chk("collect_done", idx, NCH);
    chk("busy_end", 32'(busy), 0);
    chk("wr_en_end", 32'(wr_en), 0);
    chk("miss_end", 32'(miss), 32'(start_on_last));
    rdy = 1'b0;
    @(negedge clk);
    chk("miss_clear", 32'(miss), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; rdy = 1'b0; pins = '0;
    for (int c = 0; c < NCH; c++) acc[c] = 0;

    repeat (5) begin
      @(negedge clk);
      pins = NCH'($urandom);
    end
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_din", 32'(din), 0);
    chk("rst_wr_ch", 32'(ch), 0);
    chk("rst_wr_ovf", 32'(wr_ovf), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_miss", 32'(miss), 0);
    pins = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(); collect(0, 1'b0);

    // basic counts, then the same stimulus under alternating backpressure
    settle();
    pulses(0, 5, 6, 6); pulses(3, 3, 6, 6);
    settle(); do_start(); collect(0, 1'b0);
    pulses(0, 5, 6, 6); pulses(3, 3, 6, 6);
    settle(); do_start(); collect(1, 1'b0);

    // short pulses (filtered out only when the filter is built in), then wide ones
    pulses(1, 3, 2, 6);
    settle(); do_start(); collect(0, 1'b0);
    pulses(1, 3, 6, 6);
    settle(); do_start(); collect(2, 1'b0);

    // saturation, then a fresh window; a start on the final transfer is missed
    pulses(2, 20, 6, 6);
    settle(); do_start(); collect(0, 1'b0);
    pulses(2, 2, 6, 6);
    settle(); do_start(); collect(0, 1'b1);

    // start while busy extends the window
    settle(); do_start(); rdy = 1'b0;
    pulses(4, 3, 6, 6);
    chk("busy_held", 32'(busy), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("miss_pulse", 32'(miss), 1);
    @(negedge clk);
    chk("miss_single", 32'(miss), 0);
    pulses(4, 2, 6, 6);
    collect(2, 1'b0);
    settle(); do_start(); collect(2, 1'b0);

    // ch0 edge detected in the start cycle goes to the next window
    settle();
    pins[0] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    do_start();
    acc[0] = 1;
    collect(0, 1'b0);
    pins[0] = 1'b0;
    settle(); do_start(); collect(0, 1'b0);

    // randomised windows
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < NCH; c++) begin
        n = $urandom_range(0, (c == 2) ? 18 : 4);
        for (int k = 0; k < n; k++)
          pulses(c, 1, $urandom_range(1, FL + 3), $urandom_range(FL + 1, FL + 4));
      end
      settle(); do_start(); collect(2, 1'b0);
    end

    // reset in the middle of a transfer
    pulses(6, 2, 6, 6);
    settle(); do_start();
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_wr_ch", 32'(ch), 0);
    chk("midrst_wr_din", 32'(din), 0);
    rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) acc[c] = 0;
    @(negedge clk);
    chk("post_rst_idle", 32'(wr_en), 0);
    do_start(); collect(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/turbine_pulse_counter_array.md
Name: turbine_pulse_counter_array

Overview:
- Multi-channel turbine flowmeter pulse counter with a shared, serialised write port toward the acquisition FIFO.
- Each channel synchronises its turbine pulse input, optionally glitch-filters it, and counts rising edges in an acquisition window.
- On the acquisition start pulse, all counts are snapshotted and cleared, then streamed out one word per channel under a valid/ready handshake.
- Parametrised successor of the per-channel-parallel turbine wrapper: adds configurable count width, saturation/overflow flags, backpressure and missed-window reporting.

Parameters:
- TURBINE_NUM, 10, number of channels (1..64).
- CNT_WIDTH, 16, count width per channel (4..32).
- FILT_LEN, 4, stable cycles a synchronised input must hold before the filtered level changes (1..255).
- CH_W, $clog2(TURBINE_NUM) with minimum 1, channel index width (derived; not overridden).

Ports:
- sys_clk_i  in  1  system clock, 100 MHz nominal.
- rst_i  in  1  asynchronous, active-high reset.
- turbine_acq_start_pluse_i  in  1  one-cycle pulse that closes the current window.
- turbine_pulse_i  in  TURBINE_NUM  raw asynchronous turbine pulses, one bit per channel.
- wr_ready_i  in  1  downstream can accept a word.
- wr_en_o  out  1  word valid.
- wr_din_o  out  CNT_WIDTH  snapshotted count.
- wr_ch_o  out  CH_W  channel index of the current word.
- wr_ovf_o  out  1  count saturated during the window.
- busy_o  out  1  high while in SEND.
- acq_miss_o  out  1  one-cycle pulse: start pulse ignored because busy.

Behaviour:
- Reset: every output is 0 (asynchronous). Counters, overflow flags, synchronisers, filters and snapshots are cleared; FSM goes to IDLE. Reset mid-SEND aborts the transfer; no partial resume.
- Per-channel front end:
  - Two-flop synchroniser.
  - Filter: the filtered level flips only after the synchronised value differs from it for FILT_LEN consecutive cycles. A mismatch counter resets on any agreement.
  - Rising-edge detect on the filtered level.
  - Pin-to-counter latency is 3+FILT_LEN cycles.
- Counter:
  - Increments by 1 per detected edge.
  - At all-ones it holds (saturates) and sets the channel ovf flag; the flag stays set until the next snapshot.
- FSM states IDLE, SEND.
  - IDLE: a start pulse in cycle N loads all counts and ovf flags into the snapshot registers at the N+1 clock edge. The same edge clears counters and ovf flags, sets the channel pointer to 0, and enters SEND.
  - An edge detected in cycle N is excluded from the snapshot; the new counter starts at 1 (saturation still applies).
  - SEND: wr_en_o=1; wr_din_o, wr_ch_o and wr_ovf_o present snapshot[ptr].
  - A transfer occurs on a clock with wr_en_o && wr_ready_i. Outputs hold stable until the transfer completes.
  - After a transfer: ptr increments. After the transfer with ptr = TURBINE_NUM-1, go to IDLE with wr_en_o=0 on the next cycle. Back-to-back transfers are allowed (one per cycle with ready held high).
  - Output order is always channel 0..TURBINE_NUM-1.
- Start pulse while in SEND (including the final transfer cycle):
  - The snapshot is not retaken and counters are not cleared, so the window extends.
  - acq_miss_o pulses high for 1 cycle, the cycle after the start pulse.
- busy_o equals (state == SEND).
- All outputs are registered.

Optional Feature:
- Macro: TURBINE_GLITCH_FILT_EN.
- Defined: the FILT_LEN filter is present as described above.
- Undefined: the filtered level equals the synchroniser output, FILT_LEN is ignored, and pin-to-counter latency is 3 cycles. Pulses of ≥1 cycle that reach the synchroniser are counted.

Test Plan:
- Reset: hold rst_i=1 for 50 ns with pulses toggling -> all outputs 0. After release with no activity, a start pulse -> 10 words, each with data 0 and ovf 0, channels 0..9.
- Basic count: 5 pulses on ch0 and 3 on ch3 (60 ns high / 60 ns low), wr_ready_i=1, then start -> 10 consecutive words. ch0=5, ch3=3, all others 0; wr_ch_o runs 0..9; busy_o is high for 10 cycles.
- Backpressure: same stimulus with wr_ready_i alternating 1/0 -> each word is held stable while ready=0. 10 transfers occur in order, and busy_o falls after the 10th transfer.
- Glitch filter (macro defined, FILT_LEN=4): 20 ns pulses on ch1 -> count 0; 60 ns pulses -> counted. With the macro undefined -> the 20 ns pulses are counted.
- Saturation: CNT_WIDTH=4, 20 pulses on ch2, start -> ch2 word = 15 with wr_ovf_o=1. The next window with 2 pulses -> 2 with ovf 0.
- Overlap/simultaneity:
  - Start while busy -> acq_miss_o pulses once. Pulses from both windows accumulate and appear in the next snapshot.
  - A ch0 edge detected in the start cycle -> excluded from the current word; the next window reports 1.
  - rst_i asserted mid-SEND -> wr_en_o=0 immediately and the FSM returns to IDLE.
